// File: rtl/ext_pkg.sv
// Shared definitions for the operand extender: mode codes, mode-code width
// and the legality check used by the extension core.
package ext_pkg;

  localparam int EXT_MODE_W = 3;

  localparam logic [EXT_MODE_W-1:0] EXT_ZERO   = 3'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN   = 3'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_UPPER  = 3'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_BYTE_S = 3'd3;
  localparam logic [EXT_MODE_W-1:0] EXT_BYTE_Z = 3'd4;
  localparam logic [EXT_MODE_W-1:0] EXT_HALF_S = 3'd5;

  // Half-word sign extension only makes sense when the operand has 16 bits.
  function automatic logic is_legal_mode(input logic [EXT_MODE_W-1:0] mode, input int in_w);
    return (mode <= EXT_BYTE_Z) || ((mode == EXT_HALF_S) && (in_w >= 16));
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational mode decode and extension of one operand to OUT_W bits.
// Illegal modes return a zero result with err set.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic [IN_W-1:0]       original,
  output logic [OUT_W-1:0]      result,
  output logic                  err
);

  logic [OUT_W-1:0] half_s;

  // Narrow operands have no half word; keep the bit select out of elaboration.
  generate
    if (IN_W >= 16) begin : g_half
      assign half_s = {{(OUT_W-16){original[15]}}, original[15:0]};
    end else begin : g_no_half
      assign half_s = '0;
    end
  endgenerate

  // Select the extension for the requested mode; illegal modes force zero.
  always_comb begin
    result = '0;
    err    = !is_legal_mode(mode, IN_W);
    case (mode)
      EXT_ZERO:   result = {{(OUT_W-IN_W){1'b0}}, original};
      EXT_SIGN:   result = {{(OUT_W-IN_W){original[IN_W-1]}}, original};
      EXT_UPPER:  result = {original, {(OUT_W-IN_W){1'b0}}};
      EXT_BYTE_S: result = {{(OUT_W-8){original[7]}}, original[7:0]};
      EXT_BYTE_Z: result = {{(OUT_W-8){1'b0}}, original[7:0]};
      EXT_HALF_S: result = half_s;
      default:    result = '0;
    endcase
    if (err) result = '0;
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered operand extender with a one-stage valid/ready pipeline and a
// skid register so back-pressure never drops or duplicates an operand.
// Optional feature macro EXT_ERR_CNT_EN adds out_err_cnt, a saturating count
// of illegal-mode operands accepted at the input.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int MODE_W = EXT_MODE_W
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  output logic              out_in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [IN_W-1:0]   in_original,
  output logic              out_valid,
  input  logic              in_out_ready,
  output logic [OUT_W-1:0]  out_extended,
`ifdef EXT_ERR_CNT_EN
  output logic              out_err,
  output logic [7:0]        out_err_cnt
`else
  output logic              out_err
`endif
);

  logic [OUT_W-1:0] core_result;
  logic             core_err;

  logic             main_valid, skid_valid, ready_q;
  logic [OUT_W-1:0] main_data, skid_data;
  logic             main_err, skid_err;

  logic accept, drain;
  logic main_v_n, skid_v_n;
  logic ld_main_in, ld_main_skid, ld_skid;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode     (in_mode),
    .original (in_original),
    .result   (core_result),
    .err      (core_err)
  );

  assign accept = in_valid && ready_q;
  assign drain  = main_valid && in_out_ready;

  // Decide where an accepted item lands and whether skid refills main.
  always_comb begin
    main_v_n     = main_valid;
    skid_v_n     = skid_valid;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (skid_valid) begin
      // ready is low while skid holds an item, so nothing new arrives here
      if (drain) begin
        ld_main_skid = 1'b1;
        skid_v_n     = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        ld_main_in = 1'b1;
        main_v_n   = 1'b1;
      end else begin
        ld_skid  = 1'b1;
        skid_v_n = 1'b1;
      end
    end else if (drain) begin
      main_v_n = 1'b0;
    end
  end

  // Main/skid storage; ready is registered from the next skid occupancy.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else begin
      main_valid <= main_v_n;
      skid_valid <= skid_v_n;
      ready_q    <= !skid_v_n;
      if (ld_main_in) begin
        main_data <= core_result;
        main_err  <= core_err;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (ld_skid) begin
        skid_data <= core_result;
        skid_err  <= core_err;
      end
    end
  end

  assign out_in_ready = ready_q;
  assign out_valid    = main_valid;
  assign out_extended = main_data;
  assign out_err      = main_err;

`ifdef EXT_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Count illegal operands as they are accepted, holding at 255.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      err_cnt <= 8'd0;
    end else if (accept && core_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign out_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: directed mode checks, back-pressure,
// throughput, mid-stream reset and a random phase against a reference model.
module tb_ext_unit_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             in_clk = 1'b0;
  logic             in_rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_in_ready;
  logic [2:0]       in_mode = '0;
  logic [IN_W-1:0]  in_original = '0;
  logic             out_valid;
  logic             in_out_ready = 1'b1;
  logic [OUT_W-1:0] out_extended;
  logic             out_err;
`ifdef EXT_ERR_CNT_EN
  logic [7:0]       out_err_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int model_cnt = 0;

  logic [OUT_W:0] exp_q[$];

  always #5 in_clk = ~in_clk;

  ext_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .MODE_W(3)) dut (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .in_valid     (in_valid),
    .out_in_ready (out_in_ready),
    .in_mode      (in_mode),
    .in_original  (in_original),
    .out_valid    (out_valid),
    .in_out_ready (in_out_ready),
    .out_extended (out_extended),
`ifdef EXT_ERR_CNT_EN
    .out_err      (out_err),
    .out_err_cnt  (out_err_cnt)
`else
    .out_err      (out_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: value arithmetic on integers, then wrap into OUT_W bits.
  function automatic logic [OUT_W:0] ref_ext(input int mode, input longint orig);
    longint v;
    longint b;
    logic   e;
    e = 1'b0;
    v = 0;
    case (mode)
      0: v = orig;
      1: v = (orig >= (longint'(1) << (IN_W-1))) ? orig - (longint'(1) << IN_W) : orig;
      2: v = orig * (longint'(1) << (OUT_W-IN_W));
      3: begin b = orig % 256; v = (b >= 128) ? b - 256 : b; end
      4: v = orig % 256;
      5: begin
        if (IN_W >= 16) begin
          b = orig % 65536;
          v = (b >= 32768) ? b - 65536 : b;
        end else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    if (e) v = 0;
    if (v < 0) v = v + (longint'(1) << OUT_W);
    return {e, OUT_W'(v)};
  endfunction

  // Scoreboard: observe both handshakes between edges.
  logic           prev_stall = 1'b0;
  logic [OUT_W:0] prev_out;
  always @(negedge in_clk) begin
    logic [OUT_W:0] e;
    if (!in_rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      model_cnt = 0;
    end else begin
      if (prev_stall)
        chk("hold", 64'({out_valid, out_err, out_extended}), 64'({1'b1, prev_out}));
      prev_stall = out_valid && !in_out_ready;
      prev_out   = {out_err, out_extended};
      if (out_valid && in_out_ready) begin
        n_popped++;
        if (exp_q.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_extended), 64'(e[OUT_W-1:0]));
          chk("out_err", 64'(out_err), 64'(e[OUT_W]));
        end
      end
      if (in_valid && out_in_ready) begin
        e = ref_ext(int'(in_mode), longint'(in_original));
        exp_q.push_back(e);
        n_pushed++;
        if (e[OUT_W] && model_cnt < 255) model_cnt++;
      end
    end
  end

  task automatic push_item(input logic [2:0] mode, input logic [IN_W-1:0] orig);
    in_valid    = 1'b1;
    in_mode     = mode;
    in_original = orig;
    for (int t = 0; t < 50; t++) begin
      @(negedge in_clk);
      if (out_in_ready) begin
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("push_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_single(input logic [2:0] mode, input logic [IN_W-1:0] orig,
                             input logic [OUT_W-1:0] exp_d, input logic exp_e);
    push_item(mode, orig);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("single_data", 64'(out_extended), 64'(exp_d));
    chk("single_err", 64'(out_err), 64'(exp_e));
    @(posedge in_clk);
    #1;
  endtask

  task automatic drain_all();
    in_valid = 1'b0;
    in_out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge in_clk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'(out_in_ready), 64'(0));
    chk("rst_data", 64'(out_extended), 64'(0));
    chk("rst_err", 64'(out_err), 64'(0));
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;
    chk("rel_ready", 64'(out_in_ready), 64'(1));

    // directed modes
    send_single(3'd1, 16'h8001, 32'hFFFF8001, 1'b0);
    send_single(3'd0, 16'h8001, 32'h00008001, 1'b0);
    send_single(3'd2, 16'h1234, 32'h12340000, 1'b0);
    send_single(3'd3, 16'h00F0, 32'hFFFFFFF0, 1'b0);
    send_single(3'd4, 16'h00F0, 32'h000000F0, 1'b0);
    send_single(3'd5, 16'h7FFF, 32'h00007FFF, 1'b0);
    send_single(3'd5, 16'h9001, 32'hFFFF9001, 1'b0);
    send_single(3'd6, 16'hABCD, 32'h00000000, 1'b1);
    send_single(3'd7, 16'h1234, 32'h00000000, 1'b1);

    // back-pressure: two accepts fill main and skid
    in_out_ready = 1'b0;
    push_item(3'd0, 16'h1111);
    push_item(3'd1, 16'h8222);
    chk("bp_ready_low", 64'(out_in_ready), 64'(0));
    chk("bp_hold_item1", 64'(out_extended), 64'h00001111);
    fork
      begin
        push_item(3'd2, 16'h0033);
        push_item(3'd3, 16'h0044);
      end
      begin
        repeat (4) @(posedge in_clk);
        #1;
        chk("bp_still_item1", 64'(out_extended), 64'h00001111);
        chk("bp_still_low", 64'(out_in_ready), 64'(0));
        in_out_ready = 1'b1;
      end
    join
    drain_all();

    // full throughput
    for (int i = 0; i < 100; i++) begin
      in_valid    = 1'b1;
      in_mode     = 3'($urandom_range(0, 7));
      in_original = IN_W'($urandom);
      @(negedge in_clk);
      chk("tput_ready", 64'(out_in_ready), 64'(1));
      if (i > 0) chk("tput_valid", 64'(out_valid), 64'(1));
      @(posedge in_clk);
      #1;
    end
    in_valid = 1'b0;
    chk("tput_last", 64'(out_valid), 64'(1));
    drain_all();

`ifdef EXT_ERR_CNT_EN
    for (int i = 0; i < 300; i++) push_item(3'(6 + (i % 2)), IN_W'($urandom));
    drain_all();
    chk("err_cnt_sat", 64'(out_err_cnt), 64'(model_cnt));
    chk("err_cnt_255", 64'(out_err_cnt), 64'(255));
`endif

    // random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_mode      = 3'($urandom_range(0, 7));
      in_original  = IN_W'($urandom);
      in_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge in_clk);
      #1;
    end
    drain_all();
    chk("push_pop_count", 64'(n_popped), 64'(n_pushed));

    // reset with main and skid both full
    in_out_ready = 1'b0;
    push_item(3'd0, 16'h5555);
    push_item(3'd0, 16'h6666);
    in_rst_n = 1'b0;
    @(posedge in_clk);
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_data", 64'(out_extended), 64'(0));
    chk("mrst_ready", 64'(out_in_ready), 64'(0));
    chk("mrst_err", 64'(out_err), 64'(0));
`ifdef EXT_ERR_CNT_EN
    chk("mrst_cnt", 64'(out_err_cnt), 64'(0));
`endif
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;
    chk("mrst_rel_ready", 64'(out_in_ready), 64'(1));
    in_out_ready = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    chk("mrst_no_stale", 64'(out_valid), 64'(0));
    chk("final_queue", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
Parametrised, registered immediate/data extender for the datapath. It accepts an IN_W-bit operand with a mode code and produces an OUT_W-bit result. Modes are zero, sign, upper-load (LUI-style), and byte/half extension for loads. A one-stage valid/ready pipeline with a skid register sits between decode (or memory read) and the ALU operand mux, so back-pressure never drops or duplicates an operand.

Parameters:
IN_W, 16, operand width; legal range 8 <= IN_W < OUT_W
OUT_W, 32, result width
MODE_W, 3, mode code width (fixed 3 in this revision)

Ports:
in_clk  input  1  clock; all state updates on rising edge
in_rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream operand valid
out_in_ready  output  1  block can accept an operand this cycle
in_mode  input  MODE_W  extension mode; sampled with in_valid
in_original  input  IN_W  operand; sampled with in_valid
out_valid  output  1  result valid
in_out_ready  input  1  downstream accepts the result
out_extended  output  OUT_W  extended result
out_err  output  1  result came from an illegal mode

Behaviour:
- Mode codes:
  - 0 ZERO: result = {0, in_original}.
  - 1 SIGN: result = replicate in_original[IN_W-1].
  - 2 UPPER: result = in_original << (OUT_W-IN_W), with the low bits zero.
  - 3 BYTE_S: result = sign-extend in_original[7:0].
  - 4 BYTE_Z: result = zero-extend in_original[7:0].
  - 5 HALF_S: result = sign-extend in_original[15:0]. Legal only if IN_W >= 16; otherwise illegal.
  - 6, 7: illegal. result = 0 and out_err = 1, travelling with the item.
- Extension is computed combinationally on the input side and captured into the stage registers. All widths are unsigned bit vectors; no truncation is allowed.
- Handshake: a transfer in occurs when in_valid && out_in_ready. A transfer out occurs when out_valid && in_out_ready.
- Storage: main register (drives outputs) plus one skid register.
  - out_in_ready = !skid_valid, registered.
- Per-cycle update:
  - Main empty, or main draining this cycle: an accepted item goes to main.
  - Main full and not draining: an accepted item goes to skid.
  - Main drains and skid full: skid moves to main and skid empties.
- Latency: 1 cycle from accepted input to out_valid. Sustained throughput is 1 item/cycle when in_out_ready = 1.
- Outputs hold stable while out_valid && !in_out_ready. An idle pipeline keeps its last data with out_valid = 0.
- Ordering is strictly FIFO; there is no combinational path from in_* to out_*.
- Reset (in_rst_n = 0 at an edge):
  - Registered state: main_valid = 0, skid_valid = 0, out_extended = 0, out_err = 0.
  - out_in_ready is forced 0 while in_rst_n is low, and returns to 1 on the first cycle after release.
  - Reset mid-operation discards both stored items without emitting them.
- Simultaneous in-accept and out-drain with skid empty: the new item replaces main, and out_valid stays 1.

Optional Feature:
EXT_ERR_CNT_EN
- Defined: adds output out_err_cnt (8 bits), a saturating count of illegal-mode items accepted at the input.
  - Saturates at 255.
  - Reset to 0 by in_rst_n.
  - Increments on the accepting edge, not on drain.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ext_pkg holds:
  - the mode-code localparams (EXT_ZERO=0 … EXT_HALF_S=5);
  - the MODE_W constant;
  - an is_legal_mode helper parameterised on IN_W.
- Natural sub-module ext_core: purely combinational mode decode and extension returning {err, result}.
- ext_unit_pipe holds only the main and skid registers, the handshake logic and the optional counter.

Test Plan:
- Reset then single items, IN_W=16, OUT_W=32, in_out_ready=1:
  - mode1, 0x8001 -> 0xFFFF8001, 1 cycle later, out_err=0.
  - mode0, 0x8001 -> 0x00008001.
  - mode2, 0x1234 -> 0x12340000.
- Byte/half modes:
  - mode3, 0x00F0 -> 0xFFFFFFF0.
  - mode4, 0x00F0 -> 0x000000F0.
  - mode5, 0x7FFF -> 0x00007FFF.
- Illegal modes: mode6 with any operand -> out_extended=0, out_err=1. With EXT_ERR_CNT_EN, 300 illegal items -> out_err_cnt=255.
- Back-pressure: stream 4 items with in_out_ready=0 from cycle 2.
  - out_in_ready drops after the 2nd accept.
  - Outputs hold item 1.
  - On release, items 1 through 4 emerge in order with none lost or duplicated.
- Full throughput: 100 random items at in_valid=in_out_ready=1 -> 100 outputs on consecutive cycles, each matching the reference model.
- Reset mid-stream: assert in_rst_n=0 with main and skid full -> next cycle out_valid=0, out_extended=0, out_in_ready=0; after release, out_in_ready=1 and no stale items emerge.
